if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 The block SHALL have these ports: clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 jump_en_i  input  1  redirect request from execute.
REQ-004 jump_addr_i  input  32  redirect target.
REQ-005 hold_i  input  1  decode stall; freezes the fetch stage.
REQ-006 rom_addr_o  output  32  instruction ROM read address (combinational).
REQ-007 rom_inst_i  input  32  ROM read data; synchronous ROM, data for rom_addr_o returned one cycle later.
REQ-008 inst_o  output  32  registered instruction to decode.
REQ-009 inst_addr_o  output  32  registered address of inst_o.
REQ-010 inst_valid_o  output  1  inst_o is a real fetched instruction.
REQ-011 fetch_cnt_o  output  32  count of valid instructions delivered (see Configuration).

Function
REQ-012 State SHALL be: pc_r (next fetch address), req_pc_r/req_vld_r (address and validity of the word on rom_inst_i), and the output register inst_o/inst_addr_o/inst_valid_o.
REQ-013 rom_addr_o SHALL be: 0 while rst=1; else jump_addr_i if jump_en_i=1; else req_pc_r if hold_i=1; else pc_r.
REQ-014 Normal cycle (rst=0, jump_en_i=0, hold_i=0): pc_r<=pc_r+4, req_pc_r<=pc_r, req_vld_r<=1, inst_o<=rom_inst_i, inst_addr_o<=req_pc_r, inst_valid_o<=req_vld_r.
REQ-015 Latency: a word addressed in cycle N SHALL appear on inst_o in cycle N+2; throughput one instruction per cycle.
REQ-016 Hold cycle (jump_en_i=0, hold_i=1): pc_r, req_pc_r, req_vld_r and all outputs SHALL keep their values; the ROM re-reads req_pc_r, so no instruction is lost or duplicated on release.
REQ-017 Jump cycle (jump_en_i=1, regardless of hold_i): pc_r<=jump_addr_i+4, req_pc_r<=jump_addr_i, req_vld_r<=1, inst_o<=32'h00000013 (NOP), inst_addr_o<=0, inst_valid_o<=0; exactly one bubble.
REQ-018 Jump SHALL take priority over hold; simultaneous jump_en_i and hold_i SHALL behave as a jump.
REQ-019 Consecutive jumps SHALL each redirect; only the last target's stream is delivered.
REQ-020 PC arithmetic SHALL be 32-bit modulo 2^32: 32'hFFFFFFFC+4 wraps to 0.
REQ-021 jump_addr_i SHALL be used unmodified; alignment is the producer's responsibility.

Reset
REQ-022 While rst=1 at a rising edge: pc_r<=0, req_pc_r<=0, req_vld_r<=0, inst_o<=32'h00000013, inst_addr_o<=0, inst_valid_o<=0, fetch_cnt_o<=0.
REQ-023 Reset SHALL override jump_en_i and hold_i and abort any in-flight fetch mid-operation.
REQ-024 After rst falls, first valid instruction (address 0) SHALL appear on inst_o two edges later.

Configuration
REQ-025 Macro IF_FETCH_PERF_CNT_EN SHALL control the fetch counter.
REQ-026 Defined: fetch_cnt_o increments by 1 at each edge where inst_valid_o becomes/stays 1 via REQ-014 with req_vld_r=1; wraps at 2^32; holds during hold/jump.
REQ-027 Undefined: fetch_cnt_o SHALL be constant 0 and no counter flops exist; all other behaviour identical.

Verification
REQ-028 ROM mem[i]=i+1; release reset -> inst_o=1,2,3 at addrs 0,4,8 on consecutive cycles, inst_valid_o=1 from 2nd edge.
REQ-029 hold_i=1 for 3 cycles while inst_addr_o=8 -> outputs frozen at addr 8; after release next is addr 12, no skip/duplicate.
REQ-030 jump_en_i=1, jump_addr_i=0x40 while streaming -> one NOP cycle (valid=0), then inst_addr_o=0x40, 0x44.
REQ-031 jump_en_i=1 and hold_i=1 same cycle, target 0x80 -> jump taken, next valid addr 0x80.
REQ-032 Jump to 0xFFFFFFFC -> addrs 0xFFFFFFFC then 0x00000000.
REQ-033 rst=1 mid-stream at addr 0x20 -> next edge inst_valid_o=0, inst_o=0x13, fetch_cnt_o=0; with macro, 3 valid instructions after restart -> fetch_cnt_o=3.

Source files
------------

// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage with a 2-cycle synchronous ROM pipeline, jump redirect and decode hold.
// Define IF_FETCH_PERF_CNT_EN to build the delivered-instruction counter on fetch_cnt_o.
module if_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_i,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_inst_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o,
    output logic [31:0] fetch_cnt_o
);
    localparam logic [31:0] NOP = 32'h00000013;
    logic [31:0] pc_r;
    logic [31:0] req_pc_r;
    logic        req_vld_r;
    // Holding re-reads the word already in flight so it is still on rom_inst_i at release.
    assign rom_addr_o = rst ? 32'd0 : jump_en_i ? jump_addr_i : hold_i ? req_pc_r : pc_r;
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r         <= '0;
            req_pc_r     <= '0;
            req_vld_r    <= 1'b0;
            inst_o       <= NOP;
            inst_addr_o  <= '0;
            inst_valid_o <= 1'b0;
        end else if (jump_en_i) begin
            pc_r         <= jump_addr_i + 32'd4;
            req_pc_r     <= jump_addr_i;
            req_vld_r    <= 1'b1;
            inst_o       <= NOP;
            inst_addr_o  <= '0;
            inst_valid_o <= 1'b0;
        end else if (!hold_i) begin
            pc_r         <= pc_r + 32'd4;
            req_pc_r     <= pc_r;
            req_vld_r    <= 1'b1;
            inst_o       <= rom_inst_i;
            inst_addr_o  <= req_pc_r;
            inst_valid_o <= req_vld_r;
        end
    end
`ifdef IF_FETCH_PERF_CNT_EN
    logic [31:0] cnt_r;
    always_ff @(posedge clk) begin
        if (rst)
            cnt_r <= '0;
        else if (!jump_en_i && !hold_i && req_vld_r)
            cnt_r <= cnt_r + 32'd1;
    end
    assign fetch_cnt_o = cnt_r;
`else
    assign fetch_cnt_o = '0;
`endif
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: scripted and randomized checks of if_fetch against a queue-based model of the delivered stream.
module tb_if_fetch;
    localparam logic [31:0] NOP = 32'h00000013;
`ifdef IF_FETCH_PERF_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump_en = 1'b0;
    logic [31:0] jump_addr = '0;
    logic        hold = 1'b0;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst = '0;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        inst_valid;
    logic [31:0] fetch_cnt;
    int checks = 0;
    int failures = 0;
    logic [31:0] m_q[$];
    logic [31:0] m_nxt = '0;
    logic        m_valid = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_inst = NOP;
    logic        m_known = 1'b0;
    logic [31:0] m_cnt = '0;

    if_fetch dut (
        .clk(clk), .rst(rst), .jump_en_i(jump_en), .jump_addr_i(jump_addr), .hold_i(hold),
        .rom_addr_o(rom_addr), .rom_inst_i(rom_inst), .inst_o(inst), .inst_addr_o(inst_addr),
        .inst_valid_o(inst_valid), .fetch_cnt_o(fetch_cnt)
    );

    always #5 clk = ~clk;
    // Synchronous ROM holding mem[i] = i + 1.
    always @(posedge clk) rom_inst <= (rom_addr >> 2) + 32'd1;

    function automatic logic [31:0] exp_cnt();
        return CNT_EN ? m_cnt : 32'd0;
    endfunction

    // Drive one cycle of inputs and advance the model of what decode should see.
    task automatic cycle(input logic r, input logic j, input logic h, input logic [31:0] ja);
        @(negedge clk);
        rst = r; jump_en = j; hold = h; jump_addr = ja;
        @(posedge clk);
        if (r) begin
            m_q.delete(); m_nxt = 0; m_valid = 0; m_addr = 0; m_inst = NOP; m_known = 1; m_cnt = 0;
        end else if (j) begin
            m_q.delete(); m_q.push_back(ja); m_nxt = ja + 32'd4;
            m_valid = 0; m_addr = 0; m_inst = NOP; m_known = 1;
        end else if (!h) begin
            if (m_q.size() > 0) begin
                m_addr = m_q.pop_front(); m_valid = 1; m_inst = (m_addr >> 2) + 32'd1; m_known = 1; m_cnt++;
            end else begin
                m_valid = 0; m_known = 0;
            end
            m_q.push_back(m_nxt); m_nxt = m_nxt + 32'd4;
        end
        #1;
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 0);
        cycle(1, 1, 1, 32'h100);
        checks++;
        if (inst_valid !== 1'b0 || inst !== NOP || inst_addr !== 32'd0 || fetch_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset: valid=%b inst=%h addr=%h cnt=%0d want 0/00000013/0/0", inst_valid, inst, inst_addr, fetch_cnt);
        end
    endtask

    task automatic test_stream();
        cycle(0, 0, 0, 0);
        checks++;
        if (inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL stream_first_edge: valid=%b want 0", inst_valid);
        end
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 0, 0);
            checks++;
            if (inst_valid !== 1'b1 || inst_addr !== 32'(4 * k) || inst !== 32'(k + 1) || fetch_cnt !== exp_cnt()) begin
                failures++;
                $display("FAIL stream_%0d: valid=%b addr=%h inst=%h cnt=%0d want 1/%h/%h/%0d",
                         k, inst_valid, inst_addr, inst, fetch_cnt, 32'(4 * k), 32'(k + 1), exp_cnt());
            end
        end
    endtask

    task automatic test_hold();
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 1, 32'h40);
            checks++;
            if (inst_valid !== 1'b1 || inst_addr !== 32'h8 || inst !== 32'd3 || fetch_cnt !== exp_cnt()) begin
                failures++;
                $display("FAIL hold_%0d: valid=%b addr=%h inst=%h cnt=%0d want 1/8/3/%0d", k, inst_valid, inst_addr, inst, fetch_cnt, exp_cnt());
            end
        end
        for (int k = 0; k < 2; k++) begin
            cycle(0, 0, 0, 0);
            checks++;
            if (inst_valid !== 1'b1 || inst_addr !== 32'(12 + 4 * k) || inst !== 32'(4 + k)) begin
                failures++;
                $display("FAIL hold_release_%0d: valid=%b addr=%h inst=%h want 1/%h/%h", k, inst_valid, inst_addr, inst, 32'(12 + 4 * k), 32'(4 + k));
            end
        end
    endtask

    task automatic test_jump();
        cycle(0, 1, 0, 32'h40);
        checks++;
        if (inst_valid !== 1'b0 || inst !== NOP || inst_addr !== 32'd0) begin
            failures++;
            $display("FAIL jump_bubble: valid=%b inst=%h addr=%h want 0/00000013/0", inst_valid, inst, inst_addr);
        end
        for (int k = 0; k < 2; k++) begin
            cycle(0, 0, 0, 0);
            checks++;
            if (inst_valid !== 1'b1 || inst_addr !== 32'(32'h40 + 4 * k) || inst !== 32'(17 + k)) begin
                failures++;
                $display("FAIL jump_target_%0d: valid=%b addr=%h inst=%h want 1/%h/%h", k, inst_valid, inst_addr, inst, 32'(32'h40 + 4 * k), 32'(17 + k));
            end
        end
        cycle(0, 1, 0, 32'h100);
        cycle(0, 1, 0, 32'h200);
        cycle(0, 0, 0, 0);
        checks++;
        if (inst_valid !== 1'b1 || inst_addr !== 32'h200 || inst !== 32'h81) begin
            failures++;
            $display("FAIL jump_consecutive: valid=%b addr=%h inst=%h want 1/200/81", inst_valid, inst_addr, inst);
        end
    endtask

    task automatic test_jump_hold();
        cycle(0, 1, 1, 32'h80);
        checks++;
        if (inst_valid !== 1'b0 || inst !== NOP) begin
            failures++;
            $display("FAIL jump_hold_bubble: valid=%b inst=%h want 0/00000013", inst_valid, inst);
        end
        cycle(0, 0, 0, 0);
        checks++;
        if (inst_valid !== 1'b1 || inst_addr !== 32'h80 || inst !== 32'h21) begin
            failures++;
            $display("FAIL jump_hold_target: valid=%b addr=%h inst=%h want 1/80/21", inst_valid, inst_addr, inst);
        end
    endtask

    task automatic test_wrap();
        cycle(0, 1, 0, 32'hFFFFFFFC);
        cycle(0, 0, 0, 0);
        checks++;
        if (inst_valid !== 1'b1 || inst_addr !== 32'hFFFFFFFC || inst !== 32'h40000000) begin
            failures++;
            $display("FAIL wrap_top: valid=%b addr=%h inst=%h want 1/fffffffc/40000000", inst_valid, inst_addr, inst);
        end
        cycle(0, 0, 0, 0);
        checks++;
        if (inst_valid !== 1'b1 || inst_addr !== 32'h0 || inst !== 32'h1) begin
            failures++;
            $display("FAIL wrap_zero: valid=%b addr=%h inst=%h want 1/0/1", inst_valid, inst_addr, inst);
        end
    endtask

    task automatic test_reset_mid();
        cycle(0, 1, 0, 32'h10);
        for (int k = 0; k < 5; k++) cycle(0, 0, 0, 0);
        checks++;
        if (inst_valid !== 1'b1 || inst_addr !== 32'h20) begin
            failures++;
            $display("FAIL reset_mid_setup: valid=%b addr=%h want 1/20", inst_valid, inst_addr);
        end
        cycle(1, 0, 0, 0);
        checks++;
        if (inst_valid !== 1'b0 || inst !== NOP || fetch_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid: valid=%b inst=%h cnt=%0d want 0/00000013/0", inst_valid, inst, fetch_cnt);
        end
        for (int k = 0; k < 4; k++) cycle(0, 0, 0, 0);
        checks++;
        if (fetch_cnt !== (CNT_EN ? 32'd3 : 32'd0) || inst_addr !== 32'h8) begin
            failures++;
            $display("FAIL reset_restart_cnt: cnt=%0d addr=%h want %0d/8", fetch_cnt, inst_addr, CNT_EN ? 3 : 0);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic r, j, h;
            logic [31:0] ja;
            r  = ($urandom_range(0, 49) == 0);
            j  = ($urandom_range(0, 9) == 0);
            h  = ($urandom_range(0, 4) == 0);
            ja = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 3) * 4)) : ($urandom & 32'hFFFFFFFC);
            cycle(r, j, h, ja);
            checks++;
            if (inst_valid !== m_valid || fetch_cnt !== exp_cnt() || (m_known && (inst !== m_inst || inst_addr !== m_addr))) begin
                failures++;
                $display("FAIL random_%0d: valid=%b addr=%h inst=%h cnt=%0d want %b/%h/%h/%0d",
                         n, inst_valid, inst_addr, inst, fetch_cnt, m_valid, m_addr, m_inst, exp_cnt());
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_hold();
        test_jump();
        test_jump_hold();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
